mac_accumulator_3x3: RTL and testbench
======================================

// Module: mac_accumulator_3x3
// PURPOSE
//   Sequential multiply-accumulate stage feeding the 3x3 array multiplier.
//   - Accepts 3-bit operand pairs over a valid/ready handshake and registers them.
//   - Drives the registered pair into an instance of array_multiplier_3x3.
//   - Sums TERMS consecutive 6-bit products and presents the dot-product result downstream.
// PARAMETERS
//   ACC_WIDTH  8  accumulator/result width in bits; must be >= 6.
//   TERMS      4  products per result, legal range 1..255.
// PORTS
//   clk          in   1          single clock, rising edge.
//   rst_n        in   1          asynchronous, active-low reset.
//   in_valid     in   1          operand pair valid.
//   in_ready     out  1          stage can accept an operand pair.
//   in1          in   3          multiplicand.
//   in2          in   3          multiplier.
//   out_valid    out  1          result valid; held until accepted.
//   out_ready    in   1          downstream accepts the result.
//   out_sum      out  ACC_WIDTH  accumulated sum of TERMS products.
//   out_overflow out  1          sticky flag: a carry left ACC_WIDTH during this result.
// BEHAVIOUR
//   Reset: all outputs and registers are 0, and state is ACCUM.
//     - in_ready rises on the first clock edge after rst_n deasserts.
//     - An rst_n assertion mid-operation discards partial sums and the pending result.
//   FSM states: ACCUM and HOLD.
//     - ACCUM -> HOLD on the cycle the TERMS-th product is added.
//     - HOLD -> ACCUM on the cycle out_valid && out_ready.
//   Input side:
//     - in_ready = (state==ACCUM) && (issued < TERMS).
//     - On in_valid && in_ready, in1/in2 are captured into op regs, op_vld is set for 1 cycle, and issued is incremented.
//   Accumulate side:
//     - When op_vld is set, acc <= acc + product and added is incremented.
//     - The add is (ACC_WIDTH+1) bits wide; any carry out sets the sticky ovf bit.
//     - When added reaches TERMS, state goes to HOLD.
//   Latency: last operand accepted at edge N gives out_valid=1 after edge N+2. Full throughput is 1 pair/cycle.
//   Output side:
//     - out_sum = acc and out_overflow = ovf; both are stable while out_valid is high.
//     - Accepting the result clears acc, ovf, issued and added in the same edge.
//     - in_ready is high on the next cycle.
//   Backpressure: while in HOLD, in_ready is 0 and operands are not sampled.
//   in_valid while in_ready=0 is ignored (no capture) and is not an error.
//   TERMS=1: in_ready drops right after the single accept.
// CONFIGURATION
//   SATURATE_EN defined:
//     - On carry out, acc clamps to {ACC_WIDTH{1'b1}} and stays there.
//     - out_overflow is still set.
//   SATURATE_EN undefined:
//     - acc wraps modulo 2**ACC_WIDTH.
//     - out_overflow reports the wrap.
// STRUCTURE
//   Package mac_pkg holds:
//     - OPERAND_WIDTH=3 and PRODUCT_WIDTH=6.
//     - typedef enum {ACCUM, HOLD} mac_state_t.
//     - function cnt_width(TERMS) = $clog2(TERMS+1).
//   Sub-module: the existing array_multiplier_3x3, instantiated once and driven from the op regs.
//   Counters, accumulator and FSM live in this module.
// TESTING
//   1 Reset: assert rst_n=0 mid-stream -> out_valid=0, out_sum=0, out_overflow=0; in_ready=1 one cycle after release.
//   2 Basic: TERMS=4, pairs (1,2),(3,3),(2,5),(7,1) back-to-back -> out_sum=28, out_overflow=0, out_valid 2 cycles after last accept.
//   3 Max: TERMS=4, ACC_WIDTH=8, four (7,7) pairs -> out_sum=196, out_overflow=0.
//   4 Overflow: TERMS=8, ACC_WIDTH=8, eight (7,7) pairs:
//       without SATURATE_EN -> out_sum=136, out_overflow=1;
//       with SATURATE_EN -> out_sum=255, out_overflow=1.
//   5 Backpressure: hold out_ready=0 for 10 cycles after a result:
//       out_sum stable; in_ready=0; in_valid ignored;
//       then out_ready=1 -> next 4 pairs produce an independent correct sum.
//   6 Bubbles: random in_valid gaps with (0,x) and (x,0) pairs -> sum matches a scoreboard model every result.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the 3x3 multiply-accumulate stage.
package mac_pkg;

  localparam int unsigned OPERAND_WIDTH = 3;
  localparam int unsigned PRODUCT_WIDTH = 6;

  typedef enum logic [0:0] {
    ACCUM,
    HOLD
  } mac_state_t;

  // Width of a counter that must hold values 0..terms inclusive.
  function automatic int unsigned cnt_width(input int unsigned terms);
    return $clog2(terms + 1);
  endfunction

endpackage

// File: rtl/array_multiplier_3x3.sv
// Unsigned 3x3 array multiplier: three shifted partial-product rows summed into a 6-bit product.
module array_multiplier_3x3
  import mac_pkg::*;
(
  input  logic [OPERAND_WIDTH-1:0] a_i,
  input  logic [OPERAND_WIDTH-1:0] b_i,
  output logic [PRODUCT_WIDTH-1:0] p_o
);

  logic [PRODUCT_WIDTH-1:0] row0;
  logic [PRODUCT_WIDTH-1:0] row1;
  logic [PRODUCT_WIDTH-1:0] row2;

  // Partial-product rows, one per multiplier bit, pre-shifted into product alignment.
  always_comb begin
    row0 = {3'b000, a_i & {OPERAND_WIDTH{b_i[0]}}};
    row1 = {2'b00, a_i & {OPERAND_WIDTH{b_i[1]}}, 1'b0};
    row2 = {1'b0, a_i & {OPERAND_WIDTH{b_i[2]}}, 2'b00};
    // 7*7 = 49 fits in six bits, so the row sum never carries out.
    p_o  = row0 + row1 + row2;
  end

endmodule

// File: rtl/mac_accumulator_3x3.sv
// Sequential multiply-accumulate stage: captures operand pairs over valid/ready, multiplies
// them in array_multiplier_3x3 and sums TERMS products into one result held for downstream.
// Optional build macro SATURATE_EN: accumulator clamps to all-ones on carry out instead of
// wrapping; out_overflow is set either way. ACC_WIDTH must be at least 6.
module mac_accumulator_3x3
  import mac_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned TERMS     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] in1,
  input  logic [OPERAND_WIDTH-1:0] in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     out_sum,
  output logic                     out_overflow
);

  localparam int unsigned CntW = cnt_width(TERMS);
  localparam logic [CntW-1:0] TermsC = CntW'(TERMS);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  mac_state_t               state_q, state_d;
  logic [OPERAND_WIDTH-1:0] op1_q, op1_d;
  logic [OPERAND_WIDTH-1:0] op2_q, op2_d;
  logic                     op_vld_q, op_vld_d;
  logic [CntW-1:0]          issued_q, issued_d;
  logic [CntW-1:0]          added_q, added_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;

  logic [PRODUCT_WIDTH-1:0] product;
  logic [ACC_WIDTH:0]       sum_ext;
  logic                     accept_in;
  logic                     accept_out;

  array_multiplier_3x3 u_mult (
    .a_i (op1_q),
    .b_i (op2_q),
    .p_o (product)
  );

  // Next-state for handshake, operand capture, accumulation and the ACCUM/HOLD FSM.
  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    op_vld_d    = 1'b0;
    issued_d    = issued_q;
    added_d     = added_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;

    accept_in   = in_valid && in_ready_q;
    accept_out  = out_valid_q && out_ready;
    sum_ext     = {1'b0, acc_q} + (ACC_WIDTH + 1)'(product);

    if (accept_in) begin
      op1_d    = in1;
      op2_d    = in2;
      op_vld_d = 1'b1;
      issued_d = issued_q + CntOne;
    end

    if (op_vld_q) begin
`ifdef SATURATE_EN
      // Once clamped, every later add either carries again or adds zero, so it stays clamped.
      acc_d = sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
      acc_d = sum_ext[ACC_WIDTH-1:0];
`endif
      ovf_d   = ovf_q | sum_ext[ACC_WIDTH];
      added_d = added_q + CntOne;
      if (added_d == TermsC) begin
        state_d = HOLD;
      end
    end

    // Result consumed: start a fresh dot product on the same edge.
    if (accept_out) begin
      state_d  = ACCUM;
      issued_d = '0;
      added_d  = '0;
      acc_d    = '0;
      ovf_d    = 1'b0;
    end

    // out_valid trails entry into HOLD by one edge and drops on the accepting edge.
    out_valid_d = (state_q == HOLD) && !accept_out;
    // Registered so it stays low throughout reset and rises on the first edge after it.
    in_ready_d  = (state_d == ACCUM) && (issued_d < TermsC);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      op1_q       <= '0;
      op2_q       <= '0;
      op_vld_q    <= 1'b0;
      issued_q    <= '0;
      added_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      op_vld_q    <= op_vld_d;
      issued_q    <= issued_d;
      added_q     <= added_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_mac_accumulator_3x3.sv
// Self-checking bench: two instances (TERMS=4 and TERMS=8) driven with directed and
// randomized operand streams, checked against an arithmetic dot-product model.
module tb_mac_accumulator_3x3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_valid, a_ready, a_ovalid, a_oready, a_ovf;
  logic [2:0] a_in1, a_in2;
  logic [7:0] a_sum;
  logic       b_valid, b_ready, b_ovalid, b_oready, b_ovf;
  logic [2:0] b_in1, b_in2;
  logic [7:0] b_sum;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] a_q[$];
  logic [2:0] b_q[$];
  logic [7:0] exp_sum;
  logic       exp_ovf;

  always #5 clk = ~clk;

  mac_accumulator_3x3 #(.ACC_WIDTH(8), .TERMS(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (a_valid),
    .in_ready     (a_ready),
    .in1          (a_in1),
    .in2          (a_in2),
    .out_valid    (a_ovalid),
    .out_ready    (a_oready),
    .out_sum      (a_sum),
    .out_overflow (a_ovf)
  );

  mac_accumulator_3x3 #(.ACC_WIDTH(8), .TERMS(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (b_valid),
    .in_ready     (b_ready),
    .in1          (b_in1),
    .in2          (b_in2),
    .out_valid    (b_ovalid),
    .out_ready    (b_oready),
    .out_sum      (b_sum),
    .out_overflow (b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [2:0] x, input logic [2:0] y);
    if (sel == 0) begin
      a_valid = v; a_in1 = x; a_in2 = y;
    end else begin
      b_valid = v; b_in1 = x; b_in2 = y;
    end
  endtask

  task automatic set_oready(input int sel, input logic r);
    if (sel == 0) a_oready = r;
    else b_oready = r;
  endtask

  function automatic logic rd_ready(input int sel);
    return (sel == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic rd_ovalid(input int sel);
    return (sel == 0) ? a_ovalid : b_ovalid;
  endfunction

  function automatic logic [7:0] rd_sum(input int sel);
    return (sel == 0) ? a_sum : b_sum;
  endfunction

  function automatic logic rd_ovf(input int sel);
    return (sel == 0) ? a_ovf : b_ovf;
  endfunction

  // Reference: exact integer dot product, then wrap or clamp into 8 bits.
  function automatic void model(input int n, output logic [7:0] s, output logic o);
    int total = 0;
    for (int i = 0; i < n; i++) total += int'(a_q[i]) * int'(b_q[i]);
    o = (total > 255);
`ifdef SATURATE_EN
    s = (total > 255) ? 8'd255 : total[7:0];
`else
    s = total[7:0];
`endif
  endfunction

  task automatic push_pair(input int x, input int y);
    a_q.push_back(3'(x));
    b_q.push_back(3'(y));
  endtask

  // Feed the queued pairs, then check result latency, sum and overflow flag.
  task automatic run_result(input int sel, input int n, input bit bubbles, input string tag);
    int  idx = 0;
    int  budget = 0;
    bit  v;
    bit  fire;
    while (idx < n && budget < 400) begin
      @(negedge clk);
      v = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive(sel, v, a_q[idx], b_q[idx]);
      fire = v && rd_ready(sel);
      @(posedge clk);
      if (fire) idx++;
      budget++;
    end
    check({tag, "_accept_timeout"}, idx, n);
    @(negedge clk);
    drive(sel, 1'b0, 3'd0, 3'd0);
    check({tag, "_valid_n1"}, rd_ovalid(sel), 1'b0);
    @(negedge clk);
    check({tag, "_valid_n2_low"}, rd_ovalid(sel), 1'b0);
    @(negedge clk);
    check({tag, "_valid_n3"}, rd_ovalid(sel), 1'b1);
    model(n, exp_sum, exp_ovf);
    check({tag, "_sum"}, rd_sum(sel), exp_sum);
    check({tag, "_ovf"}, rd_ovf(sel), exp_ovf);
  endtask

  // Optionally stall the result for 'hold' cycles with ignored inputs, then accept it.
  task automatic accept(input int sel, input int hold, input string tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      drive(sel, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      set_oready(sel, 1'b0);
      check({tag, "_hold_valid"}, rd_ovalid(sel), 1'b1);
      check({tag, "_hold_ready"}, rd_ready(sel), 1'b0);
      check({tag, "_hold_sum"}, rd_sum(sel), exp_sum);
    end
    @(negedge clk);
    drive(sel, 1'b0, 3'd0, 3'd0);
    set_oready(sel, 1'b1);
    @(negedge clk);
    set_oready(sel, 1'b0);
    check({tag, "_post_valid"}, rd_ovalid(sel), 1'b0);
    check({tag, "_post_ready"}, rd_ready(sel), 1'b1);
    check({tag, "_post_sum"}, rd_sum(sel), 8'd0);
    check({tag, "_post_ovf"}, rd_ovf(sel), 1'b0);
    a_q.delete();
    b_q.delete();
  endtask

  initial begin
    drive(0, 1'b0, 3'd0, 3'd0);
    drive(1, 1'b0, 3'd0, 3'd0);
    a_oready = 1'b0;
    b_oready = 1'b0;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_a_valid", a_ovalid, 1'b0);
    check("rst_a_sum", a_sum, 8'd0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_b_ovf", b_ovf, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", a_ready, 1'b0);
    @(posedge clk);
    #1;
    check("rel_ready_high", a_ready, 1'b1);

    // Mid-stream reset discards partial sums.
    @(negedge clk);
    drive(0, 1'b1, 3'd7, 3'd7);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 3'd0);
    check("mid_partial_sum", a_sum, 8'd49);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", a_sum, 8'd0);
    check("mid_rst_valid", a_ovalid, 1'b0);
    check("mid_rst_ovf", a_ovf, 1'b0);
    check("mid_rst_ready", a_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rel_ready_low", a_ready, 1'b0);
    @(posedge clk);
    #1;
    check("mid_rel_ready_high", a_ready, 1'b1);

    // Basic dot product: 2 + 9 + 10 + 7 = 28.
    push_pair(1, 2); push_pair(3, 3); push_pair(2, 5); push_pair(7, 1);
    run_result(0, 4, 1'b0, "basic");
    check("basic_const", a_sum, 8'd28);
    accept(0, 0, "basic");

    // Largest sum that fits: 4 * 49 = 196.
    for (int i = 0; i < 4; i++) push_pair(7, 7);
    run_result(0, 4, 1'b0, "max");
    check("max_const", a_sum, 8'd196);
    accept(0, 0, "max");

    // Overflow: 8 * 49 = 392 wraps to 136, or clamps to 255.
    for (int i = 0; i < 8; i++) push_pair(7, 7);
    run_result(1, 8, 1'b0, "ovf");
`ifdef SATURATE_EN
    check("ovf_const", b_sum, 8'd255);
`else
    check("ovf_const", b_sum, 8'd136);
`endif
    accept(1, 0, "ovf");

    // Backpressure: result held 10 cycles, then an independent result follows.
    for (int i = 0; i < 4; i++) push_pair($urandom_range(0, 7), $urandom_range(0, 7));
    run_result(0, 4, 1'b0, "bp1");
    accept(0, 10, "bp1");
    push_pair(3, 4); push_pair(5, 6); push_pair(1, 7); push_pair(2, 2);
    run_result(0, 4, 1'b0, "bp2");
    check("bp2_const", a_sum, 8'd53);
    accept(0, 0, "bp2");

    // Random bubbles with zero operands mixed in, on both instances.
    for (int r = 0; r < 8; r++) begin
      int sel;
      int n;
      sel = (r % 3 == 2) ? 1 : 0;
      n = (sel == 0) ? 4 : 8;
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       push_pair(0, $urandom_range(0, 7));
          1:       push_pair($urandom_range(0, 7), 0);
          default: push_pair($urandom_range(0, 7), $urandom_range(0, 7));
        endcase
      end
      run_result(sel, n, 1'b1, "bubble");
      accept(sel, $urandom_range(0, 3), "bubble");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
